// File: rtl/tt_mux_sel_if.sv
// Select-request handshake between the control-interface decoder and the
// mux select loader: valid/ready plus the requested {ena, addr} frame.
interface tt_mux_sel_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ena;

  modport master (output req_valid, output req_addr, output req_ena, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_ena, output req_ready);
endinterface

// File: rtl/tt_mux_sel_loader.sv
// Serialises a {ena, addr} select frame MSB-first onto the mux select spine
// with a generated shift clock, then strobes the chain latch.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// SH_LO | shift clock low, current frame bit presented on sh_data
// SH_HI | shift clock high, chain samples sh_data on the rising edge
// TAIL  | shift clock low after the last bit, data held
// LATCH | latch strobe high, new selection transfers atomically
module tt_mux_sel_loader #(
  parameter int ADDR_W       = 10,
  parameter int CLK_DIV      = 2,
  parameter int LATCH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  tt_mux_sel_if.slave       req,
  input  logic              abort,
  output logic              sh_data,
  output logic              sh_clk,
  output logic              sh_latch,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_ena
);
  localparam int N      = ADDR_W + 1;
  localparam int BIT_W  = $clog2(N + 1);
  localparam int PH_MAX = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0]  DIV_LD = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  LAT_LD = PH_W'(LATCH_CYCLES - 1);
  localparam logic [BIT_W-1:0] N_LD   = BIT_W'(N);
  localparam logic [BIT_W-1:0] LAST   = BIT_W'(1);

  typedef enum logic [2:0] {IDLE, SH_LO, SH_HI, TAIL, LATCH} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      frame_q, frame_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
  logic              sh_data_q, sh_data_d;
  logic              sh_clk_q, sh_clk_d;
  logic              sh_latch_q, sh_latch_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              cur_ena_q, cur_ena_d;
  logic              ph_end;

  assign req.req_ready = (state_q == IDLE);
  assign ph_end        = (ph_cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    ph_cnt_d   = ph_cnt_q;
    sh_data_d  = sh_data_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    cur_addr_d = cur_addr_q;
    cur_ena_d  = cur_ena_q;

    case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          state_d   = SH_LO;
          frame_d   = {req.req_ena, req.req_addr};
          bit_cnt_d = N_LD;
          ph_cnt_d  = DIV_LD;
        end
      end
      SH_LO: begin
        if (ph_end) begin
          state_d  = SH_HI;
          ph_cnt_d = DIV_LD;
        end else begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end
      end
      SH_HI: begin
        if (ph_end) begin
          // Rotating rather than shifting leaves the original frame in place
          // after N bits, so LATCH can publish it without a second copy.
          frame_d   = {frame_q[N-2:0], frame_q[N-1]};
          bit_cnt_d = bit_cnt_q - 1'b1;
          ph_cnt_d  = DIV_LD;
          state_d   = (bit_cnt_q == LAST) ? TAIL : SH_LO;
        end else begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end
      end
      TAIL: begin
        if (ph_end) begin
          state_d  = LATCH;
          ph_cnt_d = LAT_LD;
        end else begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end
      end
      LATCH: begin
        if (ph_end) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          cur_addr_d = frame_q[ADDR_W-1:0];
          cur_ena_d  = frame_q[N-1];
        end else begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q == SH_LO || state_q == SH_HI || state_q == TAIL)) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
      ph_cnt_d  = '0;
      bit_cnt_d = '0;
    end

    if (state_d == SH_LO) sh_data_d = frame_d[N-1];
    if (aborted_d)        sh_data_d = 1'b0;

    sh_clk_d   = (state_d == SH_HI);
    sh_latch_d = (state_d == LATCH);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      ph_cnt_q   <= '0;
      sh_data_q  <= 1'b0;
      sh_clk_q   <= 1'b0;
      sh_latch_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      cur_addr_q <= '0;
      cur_ena_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      ph_cnt_q   <= ph_cnt_d;
      sh_data_q  <= sh_data_d;
      sh_clk_q   <= sh_clk_d;
      sh_latch_q <= sh_latch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      cur_addr_q <= cur_addr_d;
      cur_ena_q  <= cur_ena_d;
    end
  end

  assign sh_data  = sh_data_q;
  assign sh_clk   = sh_clk_q;
  assign sh_latch = sh_latch_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign cur_addr = cur_addr_q;
  assign cur_ena  = cur_ena_q;
endmodule

// File: tb/tb_tt_mux_sel_loader.sv
// Bench for tt_mux_sel_loader: a default instance and a small fast instance,
// both checked every cycle against a timeline model plus literal expectations.
module tb_tt_mux_sel_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tt_mux_sel_if #(.ADDR_W(10)) ia ();
  tt_mux_sel_if #(.ADDR_W(4))  ib ();

  logic       ab_a, ab_b;
  logic       a_data, a_clk, a_latch, a_busy, a_done, a_ab, a_cena;
  logic [9:0] a_cur;
  logic       b_data, b_clk, b_latch, b_busy, b_done, b_ab, b_cena;
  logic [3:0] b_cur;

  tt_mux_sel_loader #(.ADDR_W(10), .CLK_DIV(2), .LATCH_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .req(ia), .abort(ab_a),
    .sh_data(a_data), .sh_clk(a_clk), .sh_latch(a_latch), .busy(a_busy),
    .done(a_done), .aborted(a_ab), .cur_addr(a_cur), .cur_ena(a_cena));

  tt_mux_sel_loader #(.ADDR_W(4), .CLK_DIV(1), .LATCH_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .req(ib), .abort(ab_b),
    .sh_data(b_data), .sh_clk(b_clk), .sh_latch(b_latch), .busy(b_busy),
    .done(b_done), .aborted(b_ab), .cur_addr(b_cur), .cur_ena(b_cena));

  function automatic int pn(int d);  return (d == 0) ? 11 : 5; endfunction
  function automatic int pcd(int d); return (d == 0) ? 2 : 1;  endfunction
  function automatic int plc(int d); return (d == 0) ? 2 : 1;  endfunction

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(string nm, int d, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s dut=%0d cyc=%0d got=%0h want=%0h", nm, d, cyc, got, want);
    end
  endtask

  // Expected shift-port values k cycles after acceptance (k=1 is the first SH_LO cycle).
  function automatic void expect_at(input int k, input logic [31:0] f, input int n,
                                    input int cd, output bit e_clk, output bit e_data,
                                    output bit e_chk, output bit e_latch);
    int shift_end;
    shift_end = 2 * n * cd;
    e_clk = 1'b0; e_data = 1'b0; e_chk = 1'b0; e_latch = 1'b0;
    if (k <= shift_end) begin
      e_clk  = ((k - 1) % (2 * cd)) >= cd;
      e_data = f[n - 1 - (k - 1) / (2 * cd)];
      e_chk  = 1'b1;
    end else if (k <= shift_end + cd) begin
      e_data = f[0];
      e_chk  = 1'b1;
    end else begin
      e_latch = 1'b1;
    end
  endfunction

  bit          m_ok = 1'b0;
  bit          m_act[2];
  int          m_k[2];
  logic [31:0] m_frame[2];
  logic [31:0] m_cur[2];
  bit          m_cena[2], m_done[2], m_ab[2], m_dknown[2], m_dval[2];

  always @(posedge clk) begin
    bit          v, ab, en;
    logic [31:0] ad;
    int          n, cd, lc;
    for (int d = 0; d < 2; d++) begin
      v  = (d == 0) ? ia.req_valid : ib.req_valid;
      en = (d == 0) ? ia.req_ena : ib.req_ena;
      ad = (d == 0) ? 32'(ia.req_addr) : 32'(ib.req_addr);
      ab = (d == 0) ? ab_a : ab_b;
      n = pn(d); cd = pcd(d); lc = plc(d);
      if (rst) begin
        m_act[d] = 1'b0; m_k[d] = 0; m_cur[d] = '0; m_cena[d] = 1'b0;
        m_done[d] = 1'b0; m_ab[d] = 1'b0; m_dknown[d] = 1'b1; m_dval[d] = 1'b0;
      end else begin
        m_done[d] = 1'b0;
        m_ab[d]   = 1'b0;
        if (m_act[d]) begin
          if (ab && m_k[d] <= 2 * n * cd + cd) begin
            m_act[d] = 1'b0; m_ab[d] = 1'b1; m_dknown[d] = 1'b1; m_dval[d] = 1'b0;
          end else begin
            m_k[d]++;
            if (m_k[d] == 2 * n * cd + cd + lc + 1) begin
              m_act[d]    = 1'b0;
              m_done[d]   = 1'b1;
              m_cur[d]    = m_frame[d] & ((32'd1 << (n - 1)) - 1);
              m_cena[d]   = m_frame[d][n - 1];
              m_dknown[d] = 1'b0;
            end
          end
        end else if (v) begin
          m_act[d]   = 1'b1;
          m_k[d]     = 1;
          m_frame[d] = (32'(en) << (n - 1)) | ad;
        end
      end
    end
    if (rst) m_ok = 1'b1;
    cyc++;
  end

  int          rises[2];
  int          ndone[2];
  int          done_cyc[2];
  logic [31:0] bits[2];
  bit          prev_clk[2];

  always @(negedge clk) begin
    logic [31:0] o_cur;
    bit o_clk, o_data, o_latch, o_busy, o_done, o_ab, o_rdy, o_cena;
    bit e_clk, e_data, e_chk, e_latch;
    if (m_ok) begin
      for (int d = 0; d < 2; d++) begin
        if (d == 0) begin
          o_clk = a_clk; o_data = a_data; o_latch = a_latch; o_busy = a_busy;
          o_done = a_done; o_ab = a_ab; o_rdy = ia.req_ready; o_cur = 32'(a_cur); o_cena = a_cena;
        end else begin
          o_clk = b_clk; o_data = b_data; o_latch = b_latch; o_busy = b_busy;
          o_done = b_done; o_ab = b_ab; o_rdy = ib.req_ready; o_cur = 32'(b_cur); o_cena = b_cena;
        end
        if (m_act[d]) begin
          expect_at(m_k[d], m_frame[d], pn(d), pcd(d), e_clk, e_data, e_chk, e_latch);
        end else begin
          e_clk = 1'b0; e_latch = 1'b0; e_chk = m_dknown[d]; e_data = m_dval[d];
        end
        chk("m_sh_clk", d, o_clk, e_clk);
        chk("m_sh_latch", d, o_latch, e_latch);
        if (e_chk) chk("m_sh_data", d, o_data, e_data);
        chk("m_busy", d, o_busy, m_act[d]);
        chk("m_req_ready", d, o_rdy, !m_act[d]);
        chk("m_done", d, o_done, m_done[d]);
        chk("m_aborted", d, o_ab, m_ab[d]);
        chk("m_cur_addr", d, o_cur, m_cur[d]);
        chk("m_cur_ena", d, o_cena, m_cena[d]);
        if (o_clk && !prev_clk[d]) begin
          rises[d]++;
          bits[d] = {bits[d][30:0], o_data};
        end
        prev_clk[d] = o_clk;
        if (o_done) begin
          ndone[d]++;
          done_cyc[d] = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(int c);
    while (cyc < c) tick();
  endtask

  int t, r0, d0;
  logic [31:0] tmp;

  initial begin
    ia.req_valid = 1'b0; ia.req_addr = '0; ia.req_ena = 1'b0;
    ib.req_valid = 1'b0; ib.req_addr = '0; ib.req_ena = 1'b0;
    ab_a = 1'b0; ab_b = 1'b0; rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", 0, a_busy, 0);
    chk("rst_cur_addr", 0, a_cur, 0);
    chk("rst_sh_clk", 0, a_clk, 0);
    chk("rst_req_ready", 0, ia.req_ready, 1);
    tick();
    rst = 1'b0;

    // Single load of 0x2A5/ena=1, with a second request held from T+10.
    tick();
    t = cyc; r0 = rises[0];
    ia.req_valid = 1'b1; ia.req_addr = 10'h2A5; ia.req_ena = 1'b1;
    tick();
    ia.req_valid = 1'b0; ia.req_addr = 10'h3FF; ia.req_ena = 1'b0;
    run_to(t + 10);
    ia.req_valid = 1'b1; ia.req_addr = 10'h003; ia.req_ena = 1'b0;
    run_to(t + 20); @(negedge clk);
    chk("busy_not_ready", 0, ia.req_ready, 0);
    run_to(t + 46); @(negedge clk);
    chk("latch_before", 0, a_latch, 0);
    run_to(t + 47); @(negedge clk);
    chk("latch_first", 0, a_latch, 1);
    run_to(t + 48); @(negedge clk);
    chk("latch_second", 0, a_latch, 1);
    chk("ready_last_latch", 0, ia.req_ready, 0);
    run_to(t + 49); @(negedge clk);
    chk("done_t49", 0, a_done, 1);
    chk("cur_addr_2a5", 0, a_cur, 10'h2A5);
    chk("cur_ena_1", 0, a_cena, 1);
    chk("ready_done_cycle", 0, ia.req_ready, 1);
    chk("rises_11", 0, rises[0] - r0, 11);
    tmp = bits[0];
    chk("bits_2a5", 0, tmp[10:0], 11'b11010100101);
    tick();
    ia.req_valid = 1'b0;
    r0 = rises[0];
    run_to(t + 98); @(negedge clk);
    chk("done_t98", 0, a_done, 1);
    chk("cur_addr_003", 0, a_cur, 10'h003);
    chk("cur_ena_0", 0, a_cena, 0);
    tmp = bits[0];
    chk("bits_003", 0, tmp[10:0], 11'b00000000011);
    chk("rises_11b", 0, rises[0] - r0, 11);

    // Abort after the fourth shift-clock rise.
    tick();
    t = cyc; r0 = rises[0];
    ia.req_valid = 1'b1; ia.req_addr = 10'h155; ia.req_ena = 1'b0;
    tick();
    ia.req_valid = 1'b0;
    run_to(t + 15);
    ab_a = 1'b1;
    tick();
    ab_a = 1'b0;
    @(negedge clk);
    chk("abort_sh_clk", 0, a_clk, 0);
    chk("abort_pulse", 0, a_ab, 1);
    chk("abort_ready", 0, ia.req_ready, 1);
    chk("abort_cur_addr", 0, a_cur, 10'h003);
    chk("abort_rises", 0, rises[0] - r0, 4);

    // Abort while idle is ignored.
    tick();
    ab_a = 1'b1;
    tick();
    ab_a = 1'b0;
    @(negedge clk);
    chk("idle_abort", 0, a_ab, 0);

    // Reset during LATCH.
    tick();
    t = cyc;
    ia.req_valid = 1'b1; ia.req_addr = 10'h1FF; ia.req_ena = 1'b1;
    tick();
    ia.req_valid = 1'b0;
    run_to(t + 47);
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_latch", 0, a_latch, 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_latch_low", 0, a_latch, 0);
    chk("rst_cur_zero", 0, a_cur, 0);
    chk("rst_busy_low", 0, a_busy, 0);
    d0 = ndone[0];
    run_to(t + 120); @(negedge clk);
    chk("no_done_after_rst", 0, ndone[0] - d0, 0);

    // Small instance: accept together with abort, accept wins.
    tick();
    t = cyc; d0 = ndone[1]; r0 = rises[1];
    ib.req_valid = 1'b1; ib.req_addr = 4'hF; ib.req_ena = 1'b1; ab_b = 1'b1;
    tick();
    ib.req_valid = 1'b0; ab_b = 1'b0;
    @(negedge clk);
    chk("b_busy_t1", 1, b_busy, 1);
    chk("b_clk_t1", 1, b_clk, 0);
    run_to(t + 2); @(negedge clk);
    chk("b_clk_t2", 1, b_clk, 1);
    run_to(t + 3); @(negedge clk);
    chk("b_clk_t3", 1, b_clk, 0);
    run_to(t + 20); @(negedge clk);
    chk("b_rises_5", 1, rises[1] - r0, 5);
    chk("b_one_done", 1, ndone[1] - d0, 1);
    chk("b_done_t13", 1, done_cyc[1], t + 13);
    chk("b_cur_addr", 1, b_cur, 4'hF);
    chk("b_cur_ena", 1, b_cena, 1);

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end
endmodule
